key_schedule_ctrl: RTL and testbench

Sequencer for the AES-128 key expansion datapath. It latches a cipher key on a start handshake and drives the datapath's load_enable, key_in and rcon_in so that one round key is produced per cycle. It presents round keys 0..NUM_ROUNDS to the round pipeline as a valid-qualified stream and flags completion. It sits between the top-level key interface and the key expansion datapath.

---
 rtl/key_schedule_ctrl.sv | 165 ++++++++++++++++
 tb/tb_key_schedule_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_schedule_ctrl.sv
// Sequencer for the AES-128 key expansion datapath: latches a key, primes the datapath, streams round keys.
// Optional round-key cache is built when KEY_CACHE_EN is defined.
module key_schedule_ctrl #(
    parameter int NUM_ROUNDS  = 10,
    parameter int LOAD_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         done,
    output logic         exp_load_enable,
    output logic [127:0] exp_key_in,
    output logic [31:0]  exp_rcon,
    input  logic [127:0] exp_key_out,
    output logic         rk_valid,
    output logic [3:0]   rk_round,
    output logic [127:0] rk_data
`ifdef KEY_CACHE_EN
    ,
    input  logic [3:0]   cache_rd_idx,
    output logic [127:0] cache_rd_data,
    output logic         cache_valid
`endif
);

    localparam int LCW = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
    localparam logic [LCW-1:0] LOAD_LAST  = LCW'(LOAD_CYCLES - 1);
    localparam logic [3:0]     LAST_ROUND = 4'(NUM_ROUNDS);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        EXP,
        LAST
    } state_t;

    state_t         state_q, state_d;
    logic [127:0]   key_q, key_d;
    logic [LCW-1:0] loadCnt_q, loadCnt_d;
    logic [3:0]     round_q, round_d;

    function automatic logic [7:0] rcFor(input logic [3:0] r);
        case (r)
            4'd1:    rcFor = 8'h01;
            4'd2:    rcFor = 8'h02;
            4'd3:    rcFor = 8'h04;
            4'd4:    rcFor = 8'h08;
            4'd5:    rcFor = 8'h10;
            4'd6:    rcFor = 8'h20;
            4'd7:    rcFor = 8'h40;
            4'd8:    rcFor = 8'h80;
            4'd9:    rcFor = 8'h1B;
            4'd10:   rcFor = 8'h36;
            default: rcFor = 8'h00;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            key_q     <= '0;
            loadCnt_q <= '0;
            round_q   <= '0;
        end else begin
            state_q   <= state_d;
            key_q     <= key_d;
            loadCnt_q <= loadCnt_d;
            round_q   <= round_d;
        end
    end

    // Outside EXP the datapath is held on the load path so it keeps tracking key_q.
    always_comb begin
        state_d         = state_q;
        key_d           = key_q;
        loadCnt_d       = loadCnt_q;
        round_d         = round_q;
        busy            = 1'b1;
        done            = 1'b0;
        exp_load_enable = 1'b1;
        exp_rcon        = 32'h0;
        rk_valid        = 1'b0;
        rk_round        = 4'd0;

        case (state_q)
            IDLE: begin
                busy      = 1'b0;
                loadCnt_d = '0;
                round_d   = 4'd0;
                if (start) begin
                    key_d   = key_in;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (loadCnt_q == LOAD_LAST) begin
                    state_d = EXP;
                    round_d = 4'd1;
                end else begin
                    loadCnt_d = loadCnt_q + LCW'(1);
                end
            end
            EXP: begin
                exp_load_enable = 1'b0;
                exp_rcon        = {rcFor(round_q), 24'h0};
                rk_valid        = 1'b1;
                rk_round        = round_q - 4'd1;
                if (round_q == LAST_ROUND) begin
                    state_d = LAST;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            LAST: begin
                rk_valid  = 1'b1;
                rk_round  = LAST_ROUND;
                done      = 1'b1;
                state_d   = IDLE;
                round_d   = 4'd0;
                loadCnt_d = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign exp_key_in = key_q;
    assign rk_data    = exp_key_out;

`ifdef KEY_CACHE_EN
    logic [127:0] cache_q [NUM_ROUNDS+1];
    logic [127:0] cacheRd_q;
    logic         cacheValid_q;

    // Keys are captured as they stream so a consumer can read them back in any order.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= NUM_ROUNDS; i++) begin
                cache_q[i] <= '0;
            end
            cacheRd_q    <= '0;
            cacheValid_q <= 1'b0;
        end else begin
            if (rk_valid) begin
                cache_q[rk_round] <= exp_key_out;
            end
            if (state_q == IDLE && start) begin
                cacheValid_q <= 1'b0;
            end else if (done) begin
                cacheValid_q <= 1'b1;
            end
            cacheRd_q <= (cache_rd_idx <= LAST_ROUND) ? cache_q[cache_rd_idx] : '0;
        end
    end

    assign cache_rd_data = cacheRd_q;
    assign cache_valid   = cacheValid_q;
`else
    // Default build carries no round-key storage.
`endif

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Self-checking bench for key_schedule_ctrl with a behavioural AES-128 expansion datapath stub.
// Cache checks are compiled in when KEY_CACHE_EN is defined.
module tb_key_schedule_ctrl;

    localparam int NR      = 10;
    localparam int LC      = 2;
    localparam int NUM_VEC = 15;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic         busy;
    logic         done;
    logic         exp_load_enable;
    logic [127:0] exp_key_in;
    logic [31:0]  exp_rcon;
    logic [127:0] exp_key_out;
    logic         rk_valid;
    logic [3:0]   rk_round;
    logic [127:0] rk_data;
`ifdef KEY_CACHE_EN
    logic [3:0]   cache_rd_idx;
    logic [127:0] cache_rd_data;
    logic         cache_valid;
`endif

    logic [127:0] dpKey;
    logic [127:0] mk [NR+1];
    logic [7:0]   rcTab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
    int           checks = 0;
    int           errors = 0;

    localparam logic [127:0] FK   = {32'h09cf4f3c, 32'habf71588, 32'h28aed2a6, 32'h2b7e1516};
    localparam logic [127:0] OK   = {32'hdeadbeef, 32'h01234567, 32'h89abcdef, 32'hfeedface};
    localparam logic [127:0] R1   = {32'h2a6c7605, 32'h23a33939, 32'h88542cb1, 32'ha0fafe17};
    localparam logic [127:0] R10  = {32'hb6630ca6, 32'he13f0cc8, 32'hc9ee2589, 32'hd014f9a8};
    localparam logic [127:0] Z10  = {32'h6f8f188e, 32'h23e951cf, 32'h3e92e211, 32'hb4ef5bcb};

    typedef struct {
        logic         start;
        logic [127:0] key;
        logic         busy;
        logic         done;
        logic         valid;
        logic [3:0]   round;
        logic         load;
        logic [31:0]  rcon;
        logic         chk;
        logic [127:0] data;
    } vec_t;

    vec_t vecs [NUM_VEC];

    key_schedule_ctrl #(.NUM_ROUNDS(NR), .LOAD_CYCLES(LC)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .key_in          (key_in),
        .busy            (busy),
        .done            (done),
        .exp_load_enable (exp_load_enable),
        .exp_key_in      (exp_key_in),
        .exp_rcon        (exp_rcon),
        .exp_key_out     (exp_key_out),
        .rk_valid        (rk_valid),
        .rk_round        (rk_round),
        .rk_data         (rk_data)
`ifdef KEY_CACHE_EN
        ,
        .cache_rd_idx    (cache_rd_idx),
        .cache_rd_data   (cache_rd_data),
        .cache_valid     (cache_valid)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] nextRound(input logic [127:0] k, input logic [31:0] rconWord);
        logic [31:0] rw, t, n0, n1, n2, n3;
        rw = {k[119:96], k[127:120]};
        t  = {sbox(rw[31:24]), sbox(rw[23:16]), sbox(rw[15:8]), sbox(rw[7:0])} ^ rconWord;
        n0 = k[31:0] ^ t;
        n1 = k[63:32] ^ n0;
        n2 = k[95:64] ^ n1;
        n3 = k[127:96] ^ n2;
        return {n3, n2, n1, n0};
    endfunction

    // Datapath stand-in: load path when enabled, otherwise one expansion round per cycle.
    always @(posedge clk) begin
        dpKey <= exp_load_enable ? exp_key_in : nextRound(dpKey, exp_rcon);
    end
    assign exp_key_out = dpKey;

    task automatic computeKeys(input logic [127:0] k);
        mk[0] = k;
        for (int i = 1; i <= NR; i++) mk[i] = nextRound(mk[i-1], {rcTab[i-1], 24'h0});
    endtask

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic checkState(input string tag, input logic eBusy, input logic eDone, input logic eValid,
                              input logic [3:0] eRound, input logic eLoad, input logic [31:0] eRcon);
        checkOutput({tag, ".busy"}, busy, eBusy);
        checkOutput({tag, ".done"}, done, eDone);
        checkOutput({tag, ".rk_valid"}, rk_valid, eValid);
        checkOutput({tag, ".rk_round"}, rk_round, eRound);
        checkOutput({tag, ".load_enable"}, exp_load_enable, eLoad);
        checkOutput({tag, ".rcon"}, exp_rcon, eRcon);
    endtask

    task automatic applyStimulus(input logic s, input logic [127:0] k);
        start  = s;
        key_in = k;
        @(negedge clk);
    endtask

    function automatic vec_t mkVec(input logic s, input logic [127:0] k, input logic b, input logic d,
                                   input logic v, input logic [3:0] r, input logic l, input logic [31:0] rc,
                                   input logic c, input logic [127:0] dat);
        vec_t t;
        t.start = s; t.key = k; t.busy = b; t.done = d; t.valid = v;
        t.round = r; t.load = l; t.rcon = rc; t.chk = c; t.data = dat;
        return t;
    endfunction

    initial begin
        int c;
        logic s;
        logic r;
        logic [127:0] k;

        vecs[0]  = mkVec(1, FK,   0, 0, 0, 4'd0,  1, 32'h0,        0, 128'h0);
        vecs[1]  = mkVec(0, '0,   1, 0, 0, 4'd0,  1, 32'h0,        0, 128'h0);
        vecs[2]  = mkVec(0, '0,   1, 0, 0, 4'd0,  1, 32'h0,        0, 128'h0);
        vecs[3]  = mkVec(0, '0,   1, 0, 1, 4'd0,  0, 32'h01000000, 1, FK);
        vecs[4]  = mkVec(0, '0,   1, 0, 1, 4'd1,  0, 32'h02000000, 1, R1);
        vecs[5]  = mkVec(0, '0,   1, 0, 1, 4'd2,  0, 32'h04000000, 0, 128'h0);
        vecs[6]  = mkVec(1, OK,   1, 0, 1, 4'd3,  0, 32'h08000000, 0, 128'h0);
        vecs[7]  = mkVec(0, '0,   1, 0, 1, 4'd4,  0, 32'h10000000, 0, 128'h0);
        vecs[8]  = mkVec(0, '0,   1, 0, 1, 4'd5,  0, 32'h20000000, 0, 128'h0);
        vecs[9]  = mkVec(0, '0,   1, 0, 1, 4'd6,  0, 32'h40000000, 0, 128'h0);
        vecs[10] = mkVec(0, '0,   1, 0, 1, 4'd7,  0, 32'h80000000, 0, 128'h0);
        vecs[11] = mkVec(0, '0,   1, 0, 1, 4'd8,  0, 32'h1B000000, 0, 128'h0);
        vecs[12] = mkVec(0, '0,   1, 0, 1, 4'd9,  0, 32'h36000000, 0, 128'h0);
        vecs[13] = mkVec(1, OK,   1, 1, 1, 4'd10, 1, 32'h0,        1, R10);
        vecs[14] = mkVec(0, '0,   0, 0, 0, 4'd0,  1, 32'h0,        0, 128'h0);

        rst    = 1'b1;
        start  = 1'b0;
        key_in = '0;
`ifdef KEY_CACHE_EN
        cache_rd_idx = 4'd0;
`endif
        repeat (3) @(negedge clk);
        checkState("reset", 0, 0, 0, 4'd0, 1, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        checkState("idle", 0, 0, 0, 4'd0, 1, 32'h0);

        $display("[TB] table run: FIPS-197 key with ignored starts");
        for (int i = 0; i < NUM_VEC; i++) begin
            checkState($sformatf("vec%0d", i), vecs[i].busy, vecs[i].done, vecs[i].valid,
                       vecs[i].round, vecs[i].load, vecs[i].rcon);
            if (vecs[i].chk) checkOutput($sformatf("vec%0d.rk_data", i), rk_data, vecs[i].data);
            applyStimulus(vecs[i].start, vecs[i].key);
        end

`ifdef KEY_CACHE_EN
        $display("[TB] cache sweep");
        computeKeys(FK);
        checkOutput("cache.valid_after_done", cache_valid, 1'b1);
        for (int i = NR; i >= 0; i--) begin
            cache_rd_idx = 4'(i);
            @(negedge clk);
            checkOutput($sformatf("cache.rd%0d", i), cache_rd_data, mk[i]);
        end
        cache_rd_idx = 4'd11;
        @(negedge clk);
        checkOutput("cache.rd11", cache_rd_data, 128'h0);
        applyStimulus(1, FK);
        checkOutput("cache.valid_after_start", cache_valid, 1'b0);
        repeat (13) applyStimulus(0, '0);
`endif

        $display("[TB] reset during EXP");
        applyStimulus(1, FK);
        repeat (4) applyStimulus(0, '0);
        checkOutput("midexp.rk_valid", rk_valid, 1'b1);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkState("midrst", 0, 0, 0, 4'd0, 1, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        checkState("postrst", 0, 0, 0, 4'd0, 1, 32'h0);

        $display("[TB] back-to-back starts");
        computeKeys(128'h0);
        applyStimulus(1, FK);
        repeat (12) applyStimulus(0, '0);
        checkOutput("b2b.first_done", done, 1'b1);
        applyStimulus(0, '0);
        applyStimulus(1, 128'h0);
        checkOutput("b2b.accepted", busy, 1'b1);
        repeat (12) applyStimulus(0, '0);
        checkState("b2b.last", 1, 1, 1, 4'd10, 1, 32'h0);
        checkOutput("b2b.model_r10", rk_data, mk[NR]);
        checkOutput("b2b.fips_zero_r10", rk_data, Z10);
        applyStimulus(0, '0);
        checkOutput("b2b.idle", busy, 1'b0);

        $display("[TB] randomized run");
        c = 0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            logic eValid, eLoad;
            logic [3:0] eRound;
            logic [31:0] eRcon;
            eValid = (c >= LC + 1);
            eLoad  = !((c >= LC + 1) && (c <= NR + LC));
            eRound = eValid ? 4'(c - LC - 1) : 4'd0;
            eRcon  = eLoad ? 32'h0 : {rcTab[c - LC - 1], 24'h0};
            checkState("rand", c != 0, c == NR + LC + 1, eValid, eRound, eLoad, eRcon);
            if (eValid) checkOutput($sformatf("rand.rk_data%0d", c - LC - 1), rk_data, mk[c - LC - 1]);

            s = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 79) == 0);
            k = {$urandom, $urandom, $urandom, $urandom};
            rst = r;
            if (r) begin
                c = 0;
            end else if (c == 0) begin
                if (s) begin
                    c = 1;
                    computeKeys(k);
                end
            end else begin
                c = (c == NR + LC + 1) ? 0 : c + 1;
            end
            applyStimulus(s, k);
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
